// File: rtl/tanh_seq_pkg.sv
// Shared types and constants for the tanh sequencer: FSM state encoding,
// default geometry and the fixed stage offsets of the accumulate/tanh/interp strobes.
package tanh_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  localparam int DEF_ADDR_W   = 32'd12;
  localparam int DEF_PIPE_LAT = 32'd4;

  // Cycles after a READ cycle at which each per-element stage strobe fires.
  localparam int ACC_STAGE    = 32'd1;
  localparam int TANH_STAGE   = 32'd2;
  localparam int INTERP_STAGE = 32'd3;

endpackage

// File: rtl/tanh_sequencer_if.sv
// Control/address bus of the tanh sequencer. The abort input exists only
// when TANH_SEQ_ABORT_EN is defined.
interface tanh_sequencer_if #(
  parameter int ADDR_W = 32'd12
);
  logic              run;
  logic [ADDR_W:0]   vec_len;
  logic [ADDR_W-1:0] wg_base;
`ifdef TANH_SEQ_ABORT_EN
  logic              abort;
`endif
  logic [ADDR_W-1:0] read_address;
  logic [ADDR_W-1:0] wg_address;
  logic [ADDR_W-1:0] write_address;
  logic              write_enable;
  logic              start_accumulate;
  logic              start_tanh;
  logic              start_interpolation;
  logic              busy;
  logic              done;

  modport master (
    output run, vec_len, wg_base,
`ifdef TANH_SEQ_ABORT_EN
    output abort,
`endif
    input  read_address, wg_address, write_address, write_enable,
    input  start_accumulate, start_tanh, start_interpolation, busy, done
  );

  modport slave (
    input  run, vec_len, wg_base,
`ifdef TANH_SEQ_ABORT_EN
    input  abort,
`endif
    output read_address, wg_address, write_address, write_enable,
    output start_accumulate, start_tanh, start_interpolation, busy, done
  );

endinterface

// File: rtl/tanh_strobe_pipe.sv
// Valid+index shift register tracking issued elements; taps give the stage
// strobes and the result write strobe/address PIPE_LAT cycles after issue.
module tanh_strobe_pipe
  import tanh_seq_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_idx,
  output logic              start_accumulate,
  output logic              start_tanh,
  output logic              start_interpolation,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_address,
  output logic              pending
);

  logic [PIPE_LAT-1:0] valid_r;
  logic [ADDR_W-1:0]   idx_r [PIPE_LAT];

  // Shift issued elements down the pipe; invalid slots carry index 0 so the
  // write address tap is already zero whenever no write is strobed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_r <= {PIPE_LAT{1'b0}};
      for (int i = 0; i < PIPE_LAT; i++) idx_r[i] <= {ADDR_W{1'b0}};
    end else begin
      valid_r  <= {valid_r[PIPE_LAT-2:0], issue};
      idx_r[0] <= issue ? issue_idx : {ADDR_W{1'b0}};
      for (int i = 1; i < PIPE_LAT; i++) idx_r[i] <= idx_r[i-1];
    end
  end

  assign start_accumulate    = valid_r[ACC_STAGE-1];
  assign start_tanh          = valid_r[TANH_STAGE-1];
  assign start_interpolation = valid_r[INTERP_STAGE-1];
  assign write_enable        = valid_r[PIPE_LAT-1];
  assign write_address       = idx_r[PIPE_LAT-1];
  // Elements still short of their write cycle.
  assign pending             = |valid_r[PIPE_LAT-2:0];

endmodule

// File: rtl/tanh_sequencer.sv
// Tanh sequencer top: walks N data/weight addresses and drives the per-element
// stage and write strobes. Optional abort input enabled by TANH_SEQ_ABORT_EN.
module tanh_sequencer
  import tanh_seq_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input logic           clock,
  input logic           reset,
  tanh_sequencer_if.slave bus
);

  localparam logic [ADDR_W:0]   MAX_N  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_N  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_A  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};

  state_e            state_r, state_n_s;
  logic [ADDR_W:0]   cnt_r, cnt_n_s;
  logic [ADDR_W:0]   n_r, n_n_s;
  logic [ADDR_W:0]   len_clamp_s;
  logic [ADDR_W-1:0] read_addr_r, wg_addr_r, wg_n_s;
  logic              busy_r, done_r, busy_n_s;
  logic              abort_s, pending_s;

`ifdef TANH_SEQ_ABORT_EN
  assign abort_s = bus.abort;
`else
  assign abort_s = 1'b0;
`endif

  assign len_clamp_s = (bus.vec_len > MAX_N) ? MAX_N : bus.vec_len;

  // Next-state and next-address logic. FIN also accepts run so that a held
  // run restarts READ in the cycle right after done.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    n_n_s     = n_r;
    wg_n_s    = wg_addr_r;
    case (state_r)
      ST_IDLE, ST_FIN: begin
        if (bus.run) begin
          n_n_s   = len_clamp_s;
          cnt_n_s = {(ADDR_W+1){1'b0}};
          wg_n_s  = bus.wg_base;
          if (len_clamp_s == {(ADDR_W+1){1'b0}}) state_n_s = ST_FIN;
          else                                    state_n_s = ST_READ;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if ((cnt_r + ONE_N == n_r) || abort_s) begin
          state_n_s = ST_DRAIN;
        end else begin
          cnt_n_s = cnt_r + ONE_N;
          wg_n_s  = wg_addr_r + ONE_A;
        end
      end
      ST_DRAIN: begin
        if (pending_s) state_n_s = ST_DRAIN;
        else           state_n_s = ST_FIN;
      end
      default: state_n_s = ST_IDLE;
    endcase
    // FIN is busy only when entered directly with N=0, never after a drain.
    busy_n_s = (state_n_s == ST_READ) || (state_n_s == ST_DRAIN) ||
               ((state_n_s == ST_FIN) && (state_r != ST_DRAIN));
  end

  // State and registered outputs; addresses are forced to 0 outside READ.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {(ADDR_W+1){1'b0}};
      n_r         <= {(ADDR_W+1){1'b0}};
      read_addr_r <= ZERO_A;
      wg_addr_r   <= ZERO_A;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      cnt_r       <= cnt_n_s;
      n_r         <= n_n_s;
      read_addr_r <= (state_n_s == ST_READ) ? cnt_n_s[ADDR_W-1:0] : ZERO_A;
      wg_addr_r   <= (state_n_s == ST_READ) ? wg_n_s : ZERO_A;
      busy_r      <= busy_n_s;
      done_r      <= (state_n_s == ST_FIN);
    end
  end

  tanh_strobe_pipe #(
    .ADDR_W   (ADDR_W),
    .PIPE_LAT (PIPE_LAT)
  ) u_pipe (
    .clock               (clock),
    .reset               (reset),
    .issue               (state_r == ST_READ),
    .issue_idx           (read_addr_r),
    .start_accumulate    (bus.start_accumulate),
    .start_tanh          (bus.start_tanh),
    .start_interpolation (bus.start_interpolation),
    .write_enable        (bus.write_enable),
    .write_address       (bus.write_address),
    .pending             (pending_s)
  );

  assign bus.read_address = read_addr_r;
  assign bus.wg_address   = wg_addr_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;

endmodule

// File: doc/tanh_sequencer.md
TANH_SEQUENCER -- requirements
Module: tanh_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: width of all address ports.
REQ-002 SHALL have parameter PIPE_LAT, default 4, legal range >= 4: cycles from a read to its result write.
REQ-003 SHALL have ports clock input 1 (single clock, rising edge) and reset input 1 (asynchronous, active-high).
REQ-004 SHALL have port run input 1: start request, sampled only in IDLE.
REQ-005 SHALL have port vec_len input ADDR_W+1: element count N, range 0..2^ADDR_W, latched at start.
REQ-006 SHALL have port wg_base input ADDR_W: weight base address, latched at start.
REQ-007 SHALL have ports read_address, wg_address, write_address, all output ADDR_W: data read, weight read and result write addresses.
REQ-008 SHALL have ports write_enable, start_accumulate, start_tanh, start_interpolation, busy and done, all output 1: write strobe, per-stage strobes, operation in progress, and 1-cycle completion pulse.

Function
REQ-009 SHALL implement FSM IDLE, READ, DRAIN, FIN; run=1 in IDLE at edge t0 latches vec_len and wg_base, then enters READ, or FIN if N=0.
REQ-010 SHALL, in READ cycle k (k=0..N-1, first READ cycle = t0+1), drive read_address=k and wg_address=(wg_base+k) mod 2^ADDR_W; READ SHALL end after N cycles, then enter DRAIN.
REQ-011 SHALL, outside READ, drive read_address=0 and wg_address=0.
REQ-012 SHALL assert start_accumulate, start_tanh and start_interpolation exactly 1, 2 and 3 cycles after each READ cycle, each for one cycle per element.
REQ-013 SHALL assert write_enable exactly PIPE_LAT cycles after each READ cycle, with write_address=k of that element; write_address SHALL be 0 when write_enable=0.
REQ-014 SHALL leave DRAIN in the cycle after the last write_enable, entering FIN; FIN SHALL last one cycle, assert done=1, then return to IDLE.
REQ-015 SHALL assert busy=1 in READ and DRAIN, and in FIN only when N=0; for N>0, busy SHALL span exactly N+PIPE_LAT cycles and be 0 during done.
REQ-016 SHALL ignore run outside IDLE; run held high SHALL restart only after FIN, so the new READ begins the cycle after done.
REQ-017 SHALL, for N=0, produce no strobes or writes, with busy=1 and done=1 in cycle t0+1.
REQ-018 SHALL treat vec_len>2^ADDR_W as 2^ADDR_W; addresses never wrap within a run, except wg_address as stated in REQ-010.

Reset
REQ-019 SHALL, on reset assertion, immediately force state IDLE, every output 0 and all in-flight pipeline strobes cleared, including mid-operation; no done pulse SHALL be produced for an interrupted run.
REQ-020 SHALL accept run on the first rising edge after reset deasserts.

Configuration
REQ-021 SHALL, with TANH_SEQ_ABORT_EN defined, have an input port abort 1.
REQ-022 SHALL, with TANH_SEQ_ABORT_EN defined, on abort=1 in READ, stop issuing reads from the next cycle and proceed to DRAIN, letting already-issued elements complete and write.
REQ-023 SHALL, with TANH_SEQ_ABORT_EN defined, ignore abort in IDLE, DRAIN and FIN; done SHALL still pulse after an aborted run.
REQ-024 SHALL, without TANH_SEQ_ABORT_EN, have no abort port, and every run SHALL process all N elements.

Structure
REQ-025 SHALL import from package tanh_seq_pkg the FSM state enum, default ADDR_W=12 and PIPE_LAT=4 constants, and the stage offsets 1/2/3.
REQ-026 SHALL instantiate one sub-module, tanh_strobe_pipe: a PIPE_LAT-deep valid+index shift register, reset by reset, generating the stage strobes and the write strobe/address.
REQ-027 SHALL be a counter-based design with no combinational path from run or vec_len to any output.

Verification
REQ-028 SHALL verify: N=4, PIPE_LAT=4, run pulse at t0 -> read_address 0..3 in t0+1..t0+4; write_enable t0+5..t0+8 with write_address 0..3; done at t0+9; busy high 8 cycles.
REQ-029 SHALL verify: N=0 -> busy=1 and done=1 at t0+1 only; no strobes.
REQ-030 SHALL verify: wg_base=4094, N=4 -> wg_address 4094, 4095, 0, 1.
REQ-031 SHALL verify: reset asserted at t0+3 of an N=8 run -> all outputs 0 immediately, no later strobes or done; new run accepted after release.
REQ-032 SHALL verify: run held high over two runs of N=2 -> second READ starts the cycle after first done; run pulses during busy are ignored.
REQ-033 SHALL verify, with TANH_SEQ_ABORT_EN: N=10, abort at READ k=2 -> reads 0..2 only; writes 0..2; done 1 cycle after last write.
